// File: rtl/door_timer_pkg.sv
// Shared constants for the door-sequencing timer: state encoding and tick width.
package door_timer_pkg;

    localparam int TICK_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OPENING = 2'd1,
        ST_HOLD    = 2'd2,
        ST_CLOSING = 2'd3
    } state_t;

endpackage

// File: rtl/door_elapsed.sv
// Phase-entry snapshot of the tick count and wrap-safe elapsed/expired computation.
import door_timer_pkg::*;

module door_elapsed (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [TICK_W-1:0] count,
    input  logic [TICK_W-1:0] dur,
    output logic [TICK_W-1:0] elapsed,
    output logic              expired
);

    logic [TICK_W-1:0] t0_r;

    // Snapshot register, reloaded on every phase entry or hold extension
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t0_r <= {TICK_W{1'b0}};
        end else if (load) begin
            t0_r <= count;
        end
    end

    // Modulo-2^32 subtraction keeps the measurement correct across counter rollover
    assign elapsed = count - t0_r;
    assign expired = (elapsed >= dur);

endmodule

// File: rtl/door_timer.sv
// Door cycle sequencer (IDLE -> OPENING -> HOLD -> CLOSING) timed against an external tick count.
// Optional feature: define DOOR_OBSTRUCT_EN to let obstruct/open_btn reopen a closing door.
import door_timer_pkg::*;

module door_timer #(
    parameter int unsigned T_OPEN  = 32'd50_000_000,
    parameter int unsigned T_HOLD  = 32'd150_000_000,
    parameter int unsigned T_CLOSE = 32'd50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TICK_W-1:0] count,
    input  logic              start,
    input  logic              open_btn,
    input  logic              obstruct,
    output logic              motor_open,
    output logic              motor_close,
    output logic              door_open,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state
);

    localparam logic [TICK_W-1:0] T_OPEN_C  = TICK_W'(T_OPEN);
    localparam logic [TICK_W-1:0] T_HOLD_C  = TICK_W'(T_HOLD);
    localparam logic [TICK_W-1:0] T_CLOSE_C = TICK_W'(T_CLOSE);

    state_t            state_r;
    state_t            next_state_s;
    logic              load_s;
    logic              done_s;
    logic              expired_s;
    logic [TICK_W-1:0] dur_s;
    logic [TICK_W-1:0] elapsed_s;
    logic              unused_s;

    door_elapsed u_elapsed (
        .clk     (clk),
        .rst     (rst),
        .load    (load_s),
        .count   (count),
        .dur     (dur_s),
        .elapsed (elapsed_s),
        .expired (expired_s)
    );

    // Next-state, snapshot-load and completion decode
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        done_s       = 1'b0;
        dur_s        = T_OPEN_C;
        case (state_r)
            ST_IDLE: begin
                dur_s = T_OPEN_C;
                if (start || open_btn) begin
                    next_state_s = ST_OPENING;
                    load_s       = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_OPENING: begin
                dur_s = T_OPEN_C;
                if (expired_s) begin
                    next_state_s = ST_HOLD;
                    load_s       = 1'b1;
                end else begin
                    next_state_s = ST_OPENING;
                end
            end
            ST_HOLD: begin
                dur_s = T_HOLD_C;
                // A button press restarts the hold even on the timeout edge
                if (open_btn) begin
                    next_state_s = ST_HOLD;
                    load_s       = 1'b1;
                end else if (expired_s) begin
                    next_state_s = ST_CLOSING;
                    load_s       = 1'b1;
                end else begin
                    next_state_s = ST_HOLD;
                end
            end
            ST_CLOSING: begin
                dur_s = T_CLOSE_C;
`ifdef DOOR_OBSTRUCT_EN
                if (obstruct || open_btn) begin
                    next_state_s = ST_OPENING;
                    load_s       = 1'b1;
                end else if (expired_s) begin
                    next_state_s = ST_IDLE;
                    done_s       = 1'b1;
                end else begin
                    next_state_s = ST_CLOSING;
                end
`else
                if (expired_s) begin
                    next_state_s = ST_IDLE;
                    done_s       = 1'b1;
                end else begin
                    next_state_s = ST_CLOSING;
                end
`endif
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register and registered output decode from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            motor_open  <= 1'b0;
            motor_close <= 1'b0;
            door_open   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            motor_open  <= (next_state_s == ST_OPENING);
            motor_close <= (next_state_s == ST_CLOSING);
            door_open   <= (next_state_s == ST_HOLD);
            busy        <= (next_state_s != ST_IDLE);
            done        <= done_s;
        end
    end

    assign state = state_r;

`ifdef DOOR_OBSTRUCT_EN
    assign unused_s = &{1'b0, elapsed_s};
`else
    assign unused_s = &{1'b0, elapsed_s, obstruct};
`endif

endmodule
